// File: rtl/cache_pkg.sv
// Shared definitions for the miss arbiter slice.
// Holds default bus widths, the default memory latency, the arbiter state
// encoding and a helper that turns a requester index into a response strobe.
package cache_pkg;

  localparam int unsigned DEFAULT_ADDR_LENGTH = 10;
  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_DELAY       = 50;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // One-hot response strobe for requester 'id'.
  function automatic logic [1:0] requester_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/miss_arbiter_if.sv
// Bundle of the two miss requesters, the backing memory and the response path.
// Signals:
//   miss_req[1:0], miss_addr0, miss_addr1 : requester side, into the arbiter
//   mem_rdata                             : memory read data, into the arbiter
//   mem_rd, mem_addr                      : memory read strobe/address, out
//   resp_valid[1:0], resp_data            : one-hot response strobe and data, out
//   grant_id, busy                        : current/last grantee and busy flag, out
// Modports: master = requesters + memory side, slave = arbiter side.
interface miss_arbiter_if
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_LENGTH = DEFAULT_ADDR_LENGTH,
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH
);

  logic [1:0]             miss_req;
  logic [ADDR_LENGTH-1:0] miss_addr0;
  logic [ADDR_LENGTH-1:0] miss_addr1;
  logic                   mem_rd;
  logic [ADDR_LENGTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic [1:0]             resp_valid;
  logic [DATA_WIDTH-1:0]  resp_data;
  logic                   grant_id;
  logic                   busy;

  modport master (
    output miss_req, miss_addr0, miss_addr1, mem_rdata,
    input  mem_rd, mem_addr, resp_valid, resp_data, grant_id, busy
  );

  modport slave (
    input  miss_req, miss_addr0, miss_addr1, mem_rdata,
    output mem_rd, mem_addr, resp_valid, resp_data, grant_id, busy
  );

endinterface

// File: rtl/delay_counter.sv
// Access latency counter for the miss arbiter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force the count to 0 (takes priority over enable)
//   enable     : count one cycle of an access
//   done       : high during the enabled cycle where count == DELAY-1
// The count saturates at DELAY-1 so it never wraps inside an access.
module delay_counter #(
  parameter int unsigned DELAY = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = $clog2(DELAY);
  localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

  logic [CW-1:0] count;

  // Cycle count within the current access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // Gated by enable so it pulses once per access, not while idle.
  assign done = enable && (count == LAST);

endmodule

// File: rtl/miss_arbiter.sv
// Two-requester round-robin miss arbiter in front of a fixed-latency memory.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : miss_arbiter_if.slave (requests, memory, responses, status)
// A grant latches the requester address and holds mem_rd for DELAY cycles,
// then returns the captured read data with a one-cycle one-hot resp_valid.
// The IDLE cycle after RESP is a bubble so a served requester that drops its
// level one cycle after the response is never granted twice.
module miss_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_LENGTH = DEFAULT_ADDR_LENGTH,
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned DELAY       = DEFAULT_DELAY
) (
  input  logic           clk,
  input  logic           reset,
  miss_arbiter_if.slave  bus
);

  arb_state_t             state;
  logic                   mem_rd_q;
  logic [ADDR_LENGTH-1:0] mem_addr_q;
  logic [1:0]             resp_valid_q;
  logic [DATA_WIDTH-1:0]  resp_data_q;
  logic                   grant_id_q;
  logic                   last_grant;
  logic                   busy_q;

  logic                   req_any;
  logic                   next_grant;
  logic [ADDR_LENGTH-1:0] sel_addr;
  logic                   grant;
  logic                   in_access;
  logic                   done;

  // Round-robin pick: on contention the requester that was not last served wins.
  always_comb begin
    req_any    = |bus.miss_req;
    next_grant = (bus.miss_req == 2'b11) ? ~last_grant : bus.miss_req[1];
    sel_addr   = next_grant ? bus.miss_addr1 : bus.miss_addr0;
    grant      = (state == IDLE) && req_any;
    in_access  = (state == ACCESS);
  end

  delay_counter #(
    .DELAY (DELAY)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant),
    .enable (in_access),
    .done   (done)
  );

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      grant_id_q   <= 1'b0;
      last_grant   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      resp_valid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (req_any) begin
            mem_addr_q <= sel_addr;
            grant_id_q <= next_grant;
            last_grant <= next_grant;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (done) begin
            resp_data_q  <= bus.mem_rdata;
            resp_valid_q <= requester_onehot(grant_id_q);
            mem_rd_q     <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_miss_arbiter.sv
// Self-checking bench for miss_arbiter: a schedule-based reference model
// (grant edge, latency window, bubble) checked every cycle on a DELAY=4
// instance, directed scenarios with literal expectations, randomized
// requester traffic, and a DELAY=50 instance for the long-latency case.
module tb_miss_arbiter;

  localparam int D      = 4;
  localparam int D_LONG = 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  miss_arbiter_if #(.ADDR_LENGTH(10), .DATA_WIDTH(32)) bus ();
  miss_arbiter_if #(.ADDR_LENGTH(10), .DATA_WIDTH(32)) bus50 ();

  miss_arbiter #(.ADDR_LENGTH(10), .DATA_WIDTH(32), .DELAY(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  miss_arbiter #(.ADDR_LENGTH(10), .DATA_WIDTH(32), .DELAY(D_LONG)) dut50 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus50.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (DELAY=4 instance) ----------------
  // A grant at edge g means: mem_rd seen after edges g..g+D-1, response after
  // edge g+D, back to idle after g+D+1, next grant possible from edge g+D+2.
  int          edge_n    = 0;
  bit          active    = 1'b0;
  int          g_edge    = 0;
  int          free_edge = 0;
  bit          m_gid     = 1'b0;
  bit          m_last    = 1'b1;
  bit          m_pick;
  logic [9:0]  m_addr    = '0;
  logic [31:0] m_rdata   = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      active    = 1'b0;
      free_edge = 0;
      m_gid     = 1'b0;
      m_last    = 1'b1;
      m_addr    = '0;
      m_rdata   = '0;
    end else begin
      edge_n++;
      if (active && edge_n == g_edge + D) m_rdata = bus.mem_rdata;
      if (edge_n >= free_edge && bus.miss_req != 2'b00) begin
        if (bus.miss_req == 2'b11) m_pick = !m_last;
        else                       m_pick = bus.miss_req[1];
        m_gid     = m_pick;
        m_last    = m_pick;
        m_addr    = m_pick ? bus.miss_addr1 : bus.miss_addr0;
        active    = 1'b1;
        g_edge    = edge_n;
        free_edge = edge_n + D + 2;
      end
    end
  end

  // Per-cycle comparison against the model.
  int   age;
  logic e_rd, e_busy;
  logic [1:0] e_rv;
  always @(negedge clk) begin
    if (chk_en) begin
      age    = edge_n - g_edge;
      e_rd   = active && age >= 0 && age < D;
      e_busy = active && age >= 0 && age <= D;
      e_rv   = (active && age == D) ? (m_gid ? 2'b10 : 2'b01) : 2'b00;
      cmp("mem_rd",     32'(bus.mem_rd),     32'(e_rd));
      cmp("busy",       32'(bus.busy),       32'(e_busy));
      cmp("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
      cmp("mem_addr",   32'(bus.mem_addr),   32'(m_addr));
      cmp("grant_id",   32'(bus.grant_id),   32'(m_gid));
      cmp("resp_data",  bus.resp_data,       m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int          rd_cnt, resp_at, n, done_cnt, pulses;
  bit          addr_ok;
  logic [1:0]  rv_log [0:15];
  logic [9:0]  ra_log [0:15];
  logic        rg_log [0:15];

  initial begin
    bus.miss_req   = 2'b00;
    bus.miss_addr0 = '0;
    bus.miss_addr1 = '0;
    bus.mem_rdata  = '0;
    bus50.miss_req   = 2'b00;
    bus50.miss_addr0 = '0;
    bus50.miss_addr1 = '0;
    bus50.mem_rdata  = '0;

    // Reset values
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    cmp("rst_mem_rd",     32'(bus.mem_rd),     32'h0);
    cmp("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    cmp("rst_busy",       32'(bus.busy),       32'h0);
    cmp("rst_mem_addr",   32'(bus.mem_addr),   32'h0);
    cmp("rst_grant_id",   32'(bus.grant_id),   32'h0);
    cmp("rst_resp_data",  bus.resp_data,       32'h0);
    reset = 1'b0;

    // Single request
    bus.miss_req = 2'b01; bus.miss_addr0 = 10'h032; bus.mem_rdata = 32'hDEADBEEF;
    rd_cnt = 0; resp_at = 0; addr_ok = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.mem_rd) begin
        rd_cnt++;
        if (bus.mem_addr !== 10'h032) addr_ok = 1'b0;
      end
      if (bus.resp_valid == 2'b01 && resp_at == 0) begin
        resp_at = i;
        bus.miss_req = 2'b00;
      end
    end
    cmp("single_rd_cycles", 32'(rd_cnt),  32'd4);
    cmp("single_addr_ok",   32'(addr_ok), 32'd1);
    cmp("single_resp_at",   32'(resp_at), 32'd5);
    cmp("single_resp_data", bus.resp_data, 32'hDEADBEEF);

    // Contention right after reset: requester 0 first
    reset = 1'b1; tick(); reset = 1'b0;
    bus.miss_req = 2'b11; bus.miss_addr0 = 10'h0A5; bus.miss_addr1 = 10'h1F0;
    bus.mem_rdata = 32'h0BADF00D;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.resp_valid != 2'b00 && n < 16) begin
        rv_log[n] = bus.resp_valid; ra_log[n] = bus.mem_addr; rg_log[n] = bus.grant_id;
        n++;
        bus.miss_req = bus.miss_req & ~bus.resp_valid;
      end
    end
    cmp("cont_count", 32'(n), 32'd2);
    if (n >= 2) begin
      cmp("cont_rv0", 32'(rv_log[0]), 32'h1);
      cmp("cont_ra0", 32'(ra_log[0]), 32'h0A5);
      cmp("cont_rg0", 32'(rg_log[0]), 32'h0);
      cmp("cont_rv1", 32'(rv_log[1]), 32'h2);
      cmp("cont_ra1", 32'(ra_log[1]), 32'h1F0);
      cmp("cont_rg1", 32'(rg_log[1]), 32'h1);
    end

    // Sustained contention: strict alternation
    bus.miss_req = 2'b11;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.resp_valid != 2'b00 && n < 6) begin
        rg_log[n] = bus.grant_id;
        n++;
      end
    end
    cmp("alt_count", 32'(n), 32'd6);
    for (int i = 0; i < n; i++) cmp("alt_gid", 32'(rg_log[i]), 32'(i % 2));
    bus.miss_req = 2'b00;
    repeat (10) tick();

    // Withdrawal in access cycle 2 does not abort
    bus.miss_req = 2'b01; bus.miss_addr0 = 10'h2AA; bus.mem_rdata = 32'hCAFE0001;
    tick(); tick();
    bus.miss_req = 2'b00;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.resp_valid == 2'b01) pulses++;
    end
    cmp("withdraw_pulses", 32'(pulses), 32'd1);
    cmp("withdraw_data",   bus.resp_data, 32'hCAFE0001);

    // Reset mid-access
    bus.miss_req = 2'b10; bus.miss_addr1 = 10'h155; bus.mem_rdata = 32'h5555AAAA;
    tick(); tick();
    reset = 1'b1;
    #1;
    cmp("rstmid_mem_rd", 32'(bus.mem_rd), 32'h0);
    cmp("rstmid_busy",   32'(bus.busy),   32'h0);
    bus.miss_req = 2'b00;
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.resp_valid != 2'b00) pulses++;
    end
    cmp("rstmid_no_resp", 32'(pulses), 32'd0);
    bus.miss_req = 2'b10;
    pulses = 0; addr_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.resp_valid == 2'b10) begin
        pulses++;
        addr_ok = (bus.mem_addr == 10'h155);
        bus.miss_req = 2'b00;
      end
    end
    cmp("after_rst_pulses", 32'(pulses), 32'd1);
    cmp("after_rst_addr",   32'(addr_ok), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.mem_rdata = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (bus.resp_valid[i]) begin
          bus.miss_req[i] = 1'b0;
        end else if (!bus.miss_req[i]) begin
          if ($urandom_range(0, 3) == 0) bus.miss_req[i] = 1'b1;
        end else if ($urandom_range(0, 63) == 0) begin
          bus.miss_req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
          if (i == 0) bus.miss_addr0 = 10'($urandom);
          else        bus.miss_addr1 = 10'($urandom);
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    bus.miss_req = 2'b00;
    repeat (10) tick();

    // Long latency instance
    bus50.miss_req = 2'b01; bus50.miss_addr0 = 10'h3FF; bus50.mem_rdata = 32'h12345678;
    rd_cnt = 0; done_cnt = 0; pulses = 0; resp_at = 0; addr_ok = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (bus50.mem_rd) begin
        rd_cnt++;
        if (bus50.mem_addr !== 10'h3FF) addr_ok = 1'b0;
      end
      if (dut50.u_counter.done) done_cnt++;
      if (bus50.resp_valid != 2'b00) begin
        pulses++;
        if (resp_at == 0) resp_at = i;
        bus50.miss_req = 2'b00;
      end
    end
    cmp("long_rd_cycles", 32'(rd_cnt),   32'd50);
    cmp("long_done",      32'(done_cnt), 32'd1);
    cmp("long_pulses",    32'(pulses),   32'd1);
    cmp("long_resp_at",   32'(resp_at),  32'd51);
    cmp("long_addr_ok",   32'(addr_ok),  32'd1);
    cmp("long_data",      bus50.resp_data, 32'h12345678);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
